conv_pool_unit: RTL and testbench

Post-processing stage directly downstream of the convolution accelerator wrapper. It consumes the accelerator's 32-bit signed output stream (row-major, channel by channel) and applies ReLU, an arithmetic right-shift requantize with saturation to 8-bit unsigned, and 2x2/stride-2 max pooling. Pooled bytes are packed four per 32-bit word, little-endian, for write-back into the next layer's input buffer.

---
 rtl/conv_pool_unit.sv | 197 +++++++++++++++++++
 tb/tb_conv_pool_unit.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_pool_unit.sv
// Post-conv stage: ReLU, shift-requantize to u8, 2x2/2 max pool, pack 4 bytes per word.
// Latency: 1 cycle from the accepting input transfer to out_valid; input stalls while output is held.
module conv_pool_unit #(
    parameter int MAX_W   = 256,
    parameter int CH_BITS = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [8:0]         cfg_width,
    input  logic [8:0]         cfg_height,
    input  logic [CH_BITS-1:0] cfg_channels,
    input  logic [4:0]         cfg_shift,
    output logic               busy,
    output logic               done,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_data,
    output logic               out_last
);

    localparam int LB_D  = MAX_W / 2;
    localparam int LB_AW = $clog2(LB_D);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, FIN} state_t;

    state_t             state_q;
    logic [8:0]         w_q, h_q, x_q, y_q;
    logic [CH_BITS-1:0] c_q, ch_q;
    logic [4:0]         shift_q;
    logic [7:0]         pair_q;
    logic [23:0]        pack_q;
    logic [1:0]         idx_q;
    logic               out_valid_q, out_last_q, done_q;
    logic [31:0]        out_data_q;

    logic [7:0]         lb [LB_D];

    logic               out_free, xfer, cfg_bad;
    logic signed [31:0] shifted;
    logic [7:0]         q, pair_max, lb_rd, pool_byte;
    logic [8:0]         w_ev, h_ev;
    logic [LB_AW-1:0]   lb_addr;
    logic               lb_we, pool_vld, word_full, final_byte, ch_end, last_ch;
    logic [1:0]         idx_d;

    assign out_free = !out_valid_q || out_ready;
    assign in_ready = (state_q == RUN) && out_free;
    assign xfer     = in_valid && in_ready;
    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;

    assign cfg_bad = (cfg_width < 9'd2) || (cfg_height < 9'd2) || (cfg_channels == '0)
                  || ({23'd0, cfg_width} > 32'(MAX_W));

    assign shifted = $signed(in_data) >>> shift_q;

    always_comb begin
        q = shifted[7:0];
        if (in_data[31])
            q = 8'd0;
        else if (|shifted[31:8])
            q = 8'hFF;
    end

    assign w_ev      = {w_q[8:1], 1'b0};
    assign h_ev      = {h_q[8:1], 1'b0};
    assign lb_addr   = x_q[LB_AW:1];
    assign lb_rd     = lb[lb_addr];
    assign pair_max  = (q > pair_q) ? q : pair_q;
    assign pool_byte = (pair_max > lb_rd) ? pair_max : lb_rd;

    // An odd x always closes a valid pair; only even rows need the odd-H trim.
    assign lb_we      = xfer && x_q[0] && !y_q[0] && (y_q < h_ev);
    assign pool_vld   = xfer && x_q[0] && y_q[0];
    assign word_full  = pool_vld && (idx_q == 2'd3);
    assign final_byte = (x_q + 9'd1 == w_ev) && (y_q + 9'd1 == h_ev);
    assign ch_end     = xfer && (x_q == w_q - 9'd1) && (y_q == h_q - 9'd1);
    assign last_ch    = (ch_q == c_q - CH_BITS'(1));
    assign idx_d      = pool_vld ? idx_q + 2'd1 : idx_q;

    always_ff @(posedge clk) begin
        if (lb_we)
            lb[lb_addr] <= pair_max;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            w_q         <= '0;
            h_q         <= '0;
            c_q         <= '0;
            shift_q     <= '0;
            x_q         <= '0;
            y_q         <= '0;
            ch_q        <= '0;
            pair_q      <= '0;
            pack_q      <= '0;
            idx_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (out_valid_q && out_ready)
                out_valid_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (start) begin
                        w_q     <= cfg_width;
                        h_q     <= cfg_height;
                        c_q     <= cfg_channels;
                        shift_q <= cfg_shift;
                        x_q     <= '0;
                        y_q     <= '0;
                        ch_q    <= '0;
                        pack_q  <= '0;
                        idx_q   <= '0;
                        state_q <= cfg_bad ? FIN : RUN;
                    end
                end

                RUN: begin
                    if (xfer) begin
                        if (!x_q[0])
                            pair_q <= q;

                        if (x_q == w_q - 9'd1) begin
                            x_q <= '0;
                            y_q <= (y_q == h_q - 9'd1) ? 9'd0 : y_q + 9'd1;
                        end else begin
                            x_q <= x_q + 9'd1;
                        end

                        if (word_full) begin
                            out_data_q  <= {pool_byte, pack_q};
                            out_valid_q <= 1'b1;
                            out_last_q  <= last_ch && final_byte;
                            pack_q      <= '0;
                        end else if (pool_vld) begin
                            case (idx_q)
                                2'd0:    pack_q[7:0]   <= pool_byte;
                                2'd1:    pack_q[15:8]  <= pool_byte;
                                default: pack_q[23:16] <= pool_byte;
                            endcase
                        end
                        idx_q <= idx_d;

                        if (ch_end) begin
                            if (idx_d != 2'd0)
                                state_q <= FLUSH;
                            else if (last_ch)
                                state_q <= FIN;
                            else
                                ch_q <= ch_q + CH_BITS'(1);
                        end
                    end
                end

                FLUSH: begin
                    // Unused upper bytes are already zero: pack_q is cleared on every emit.
                    if (out_free) begin
                        out_data_q  <= {8'd0, pack_q};
                        out_valid_q <= 1'b1;
                        out_last_q  <= last_ch;
                        pack_q      <= '0;
                        idx_q       <= '0;
                        if (last_ch) begin
                            state_q <= FIN;
                        end else begin
                            ch_q    <= ch_q + CH_BITS'(1);
                            state_q <= RUN;
                        end
                    end
                end

                FIN: begin
                    if (out_free) begin
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_pool_unit.sv
module tb_conv_pool_unit;

    logic        clk, rst, start;
    logic [8:0]  cfg_width, cfg_height;
    logic [9:0]  cfg_channels;
    logic [4:0]  cfg_shift;
    logic        busy, done, in_valid, in_ready, out_valid, out_ready, out_last;
    logic [31:0] in_data, out_data;

    conv_pool_unit #(.MAX_W(256), .CH_BITS(10)) dut (
        .clk(clk), .rst(rst), .start(start),
        .cfg_width(cfg_width), .cfg_height(cfg_height),
        .cfg_channels(cfg_channels), .cfg_shift(cfg_shift),
        .busy(busy), .done(done),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", tag, got, exp);
        end
    endtask

    int          px[$];
    logic [31:0] exp_dat[$];
    bit          exp_last[$];
    logic [31:0] obs_dat[$];
    bit          obs_last[$];
    int          in_cnt, done_cnt, done_outs, viol, stall_cnt;
    int          rdy_mode, bp_left;
    bit          bp_arm, prev_stall;
    logic [31:0] prev_dat;
    logic        prev_last;

    // Consumer side: always ready, random, or a single 10-cycle stall on the first word.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0: out_ready = 1'b1;
                1: out_ready = ($urandom_range(0, 9) < 7);
                default: begin
                    if (bp_left > 0) begin
                        out_ready = 1'b0;
                        bp_left--;
                    end else if (bp_arm && out_valid) begin
                        bp_arm    = 1'b0;
                        out_ready = 1'b0;
                        bp_left   = 9;
                    end else begin
                        out_ready = 1'b1;
                    end
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            obs_dat.push_back(out_data);
            obs_last.push_back(out_last);
        end
        if (done) begin
            done_cnt++;
            done_outs = obs_dat.size();
        end
        if (in_valid && in_ready)
            in_cnt++;
        if (in_ready && out_valid && !out_ready)
            viol++;
        if (prev_stall && (!out_valid || out_data !== prev_dat || out_last !== prev_last))
            viol++;
        if (out_valid && !out_ready && rst)
            stall_cnt++;
        prev_stall = out_valid && !out_ready && rst;
        prev_dat   = out_data;
        prev_last  = out_last;
    end

    function automatic int quant(input int v, input int sh);
        int s;
        if (v < 0) return 0;
        s = v >>> sh;
        return (s > 255) ? 255 : s;
    endfunction

    task automatic build_exp(input int w, input int h, input int c, input int sh);
        exp_dat.delete();
        exp_last.delete();
        for (int ch = 0; ch < c; ch++) begin
            int bytes[$];
            for (int py = 0; py < h / 2; py++)
                for (int pxx = 0; pxx < w / 2; pxx++) begin
                    int m = 0;
                    for (int dy = 0; dy < 2; dy++)
                        for (int dx = 0; dx < 2; dx++) begin
                            int v = quant(px[ch*w*h + (2*py+dy)*w + 2*pxx+dx], sh);
                            if (v > m) m = v;
                        end
                    bytes.push_back(m);
                end
            for (int i = 0; i < bytes.size(); i += 4) begin
                logic [31:0] wd = '0;
                for (int k = 0; k < 4; k++)
                    if (i + k < bytes.size()) wd[8*k +: 8] = bytes[i+k][7:0];
                exp_dat.push_back(wd);
                exp_last.push_back((ch == c - 1) && (i + 4 >= bytes.size()));
            end
        end
    endtask

    task automatic clear_stats(input int mode);
        rdy_mode = mode;
        bp_arm   = 1'b1;
        bp_left  = 0;
        obs_dat.delete();
        obs_last.delete();
        in_cnt = 0; done_cnt = 0; done_outs = -1; viol = 0; stall_cnt = 0;
    endtask

    task automatic pulse_start(input int w, input int h, input int c, input int sh);
        @(posedge clk); #1;
        cfg_width = 9'(w); cfg_height = 9'(h); cfg_channels = 10'(c); cfg_shift = 5'(sh);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    function automatic logic [31:0] obs_word(input int i);
        return (i < obs_dat.size()) ? obs_dat[i] : 32'hDEAD_BEEF;
    endfunction

    task automatic run_job(input string tag, input int w, input int h, input int c,
                           input int sh, input int mode);
        int n, idx, cyc, nw;
        bit xf;
        n = px.size();
        build_exp(w, h, c, sh);
        clear_stats(mode);
        pulse_start(w, h, c, sh);
        idx = 0; cyc = 0;
        while (idx < n && cyc < 20000) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_data  = px[idx];
            @(negedge clk);
            xf = in_valid && in_ready;
            @(posedge clk); #1;
            if (xf) idx++;
            cyc++;
        end
        in_valid = 1'b0;
        check({tag, "_feed"}, idx, n);
        cyc = 0;
        while (done_cnt == 0 && cyc < 2000) begin
            @(posedge clk);
            cyc++;
        end
        repeat (3) @(posedge clk);
        #1;
        check({tag, "_in_cnt"}, in_cnt, n);
        check({tag, "_nwords"}, obs_dat.size(), exp_dat.size());
        nw = (obs_dat.size() < exp_dat.size()) ? obs_dat.size() : exp_dat.size();
        for (int i = 0; i < nw; i++) begin
            check({tag, "_data"}, obs_dat[i], exp_dat[i]);
            check({tag, "_last"}, 32'(obs_last[i]), 32'(exp_last[i]));
        end
        check({tag, "_done_cnt"}, done_cnt, 1);
        check({tag, "_done_after_out"}, done_outs, exp_dat.size());
        check({tag, "_protocol"}, viol, 0);
    endtask

    task automatic bad_cfg(input string tag, input int w, input int h, input int c);
        clear_stats(0);
        @(posedge clk); #1;
        cfg_width = 9'(w); cfg_height = 9'(h); cfg_channels = 10'(c); cfg_shift = 5'd0;
        in_valid = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check({tag, "_busy"}, busy, 1);
        check({tag, "_done_early"}, done, 0);
        check({tag, "_in_ready"}, in_ready, 0);
        @(negedge clk);
        check({tag, "_done"}, done, 1);
        @(negedge clk);
        check({tag, "_done_clr"}, done, 0);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check({tag, "_in_cnt"}, in_cnt, 0);
        check({tag, "_nwords"}, obs_dat.size(), 0);
        check({tag, "_done_cnt"}, done_cnt, 1);
    endtask

    function automatic int rand_pix();
        case ($urandom_range(0, 3))
            0:       return $urandom_range(0, 300);
            1:       return -int'($urandom_range(1, 100000));
            2:       return int'($urandom_range(0, 70000));
            default: return $signed($urandom());
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, h, c, sh;
        rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0;
        cfg_width = '0; cfg_height = '0; cfg_channels = '0; cfg_shift = '0;
        clear_stats(0);
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_last", out_last, 0);
        @(posedge clk); #1;
        rst = 1'b1;

        px.delete();
        for (int i = 1; i <= 8; i++) px.push_back(i);
        run_job("t_w4h2", 4, 2, 1, 0, 0);
        check("t_w4h2_const", obs_word(0), 32'h0000_0806);

        px.delete();
        for (int i = 0; i < 32; i++) px.push_back(1000);
        run_job("t_sat_sh2", 8, 2, 2, 2, 1);
        check("t_sat_sh2_w0", obs_word(0), 32'hFAFA_FAFA);
        check("t_sat_sh2_w1", obs_word(1), 32'hFAFA_FAFA);

        px = '{-5, 300, -1, 7};
        run_job("t_negsat", 2, 2, 1, 0, 0);
        check("t_negsat_const", obs_word(0), 32'h0000_00FF);

        px.delete();
        for (int i = 0; i < 15; i++) px.push_back(i);
        run_job("t_odd", 5, 3, 1, 0, 0);
        check("t_odd_const", obs_word(0), 32'h0000_0806);

        px.delete();
        for (int i = 0; i < 8 * 6 * 2; i++) px.push_back(rand_pix());
        run_job("t_bp", 8, 6, 2, 3, 2);
        check("t_bp_stall", 32'(stall_cnt >= 10), 1);

        for (int j = 0; j < 25; j++) begin
            w = $urandom_range(2, 12);
            h = $urandom_range(2, 7);
            c = $urandom_range(1, 3);
            sh = $urandom_range(0, 12);
            px.delete();
            for (int i = 0; i < w * h * c; i++) px.push_back(rand_pix());
            run_job("t_rand", w, h, c, sh, $urandom_range(0, 1));
        end

        bad_cfg("t_w1", 1, 4, 1);
        bad_cfg("t_c0", 4, 4, 0);
        bad_cfg("t_wbig", 300, 4, 1);

        clear_stats(0);
        pulse_start(8, 4, 2, 0);
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            in_data  = 32'(i * 7);
            @(posedge clk); #1;
        end
        rst = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_in_ready", in_ready, 0);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_out_data", out_data, 0);
        check("mid_rst_out_last", out_last, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (20) @(negedge clk);
        check("mid_rst_no_done", done_cnt, 0);

        px.delete();
        for (int i = 1; i <= 8; i++) px.push_back(i);
        run_job("t_after_rst", 4, 2, 1, 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
